seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the clock's 4-digit common-anode seven-segment display. It latches the four BCD digits (HH:MM) once per frame and presents one digit code at a time to the single shared BCD-to-7-segment decoder. It drives the matching active-low anode, with a dark guard interval between digits to suppress ghosting. It sits between the time-keeping counters and the decoder/display pins.

---
 rtl/seg_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Latches HH:MM once per frame, steps one digit per slot with a dark guard interval
// at the start of each slot, and presents the digit code to a shared decoder.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       lz_blank,
  input  logic       colon,
  output logic [3:0] bcd_out,
  output logic [3:0] an_n,
  output logic       dp_n,
  output logic       frame_start
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_DRIVE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic [3:0]    q0, q1, q2, q3;
  logic [3:0]    q0_nx, q1_nx, q2_nx, q3_nx;
  logic          latch;
  logic [3:0]    code_nx;
  logic [3:0]    bcd_nx, an_nx;
  logic          dp_nx, fs_nx;

  // Next-state logic: slot counter, digit index and frame latch point
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    latch    = 1'b0;
    if (!en) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      idx_nx   = 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_GUARD;
          cnt_nx   = '0;
          idx_nx   = 2'd0;
          latch    = 1'b1;
        end
        S_GUARD: begin
          cnt_nx = cnt + CW'(1);
          if (cnt == CW'(GUARD - 1)) state_nx = S_DRIVE;
        end
        S_DRIVE: begin
          if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt_nx   = '0;
            idx_nx   = idx + 2'd1;
            state_nx = S_GUARD;
            latch    = (idx == 2'd3);
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          idx_nx   = 2'd0;
        end
      endcase
    end
  end

  // Digits as they will be held after this edge; a fresh latch feeds the first slot directly
  always_comb begin
    q0_nx = latch ? d0 : q0;
    q1_nx = latch ? d1 : q1;
    q2_nx = latch ? d2 : q2;
    q3_nx = latch ? d3 : q3;
  end

  // Code for the upcoming digit, with optional leading-zero blanking on the hours tens
  always_comb begin
    code_nx = CODE_BLANK;
    case (idx_nx)
      2'd0: code_nx = q0_nx;
      2'd1: code_nx = q1_nx;
      2'd2: code_nx = q2_nx;
      2'd3: code_nx = (lz_blank && (q3_nx == 4'd0)) ? CODE_BLANK : q3_nx;
      default: code_nx = CODE_BLANK;
    endcase
  end

  // Output values for the upcoming cycle; registered below so nothing is combinational to pins
  always_comb begin
    bcd_nx = CODE_BLANK;
    an_nx  = 4'b1111;
    dp_nx  = 1'b1;
    fs_nx  = 1'b0;
    if (state_nx != S_IDLE) begin
      bcd_nx = code_nx;
      fs_nx  = latch;
      if (state_nx == S_DRIVE) begin
        an_nx = ~(4'b0001 << idx_nx);
        dp_nx = !((idx_nx == 2'd2) && colon);
      end
    end
  end

  // State, counters, latched digits and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= 2'd0;
      q0          <= 4'hF;
      q1          <= 4'hF;
      q2          <= 4'hF;
      q3          <= 4'hF;
      bcd_out     <= CODE_BLANK;
      an_n        <= 4'b1111;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      q0          <= q0_nx;
      q1          <= q1_nx;
      q2          <= q2_nx;
      q3          <= q3_nx;
      bcd_out     <= bcd_nx;
      an_n        <= an_nx;
      dp_n        <= dp_nx;
      frame_start <= fs_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: explicit frame table, directed corner cases,
// and randomized stimulus against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned RD    = 8;
  localparam int unsigned GD    = 2;
  localparam int          FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       reset, en, lz_blank, colon;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] bcd_out, an_n;
  logic       dp_n, frame_start;

  int checks = 0;
  int passed = 0;

  // Reference model: whether scanning, position within the frame, frame's latched digits
  bit         m_act = 1'b0;
  int         m_t   = 0;
  logic [3:0] mq [4];

  typedef struct {
    int         n;
    logic [3:0] an;
    logic [3:0] bcd;
  } seg_t;
  seg_t tbl [8];

  seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk(clk), .reset(reset), .en(en),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .lz_blank(lz_blank), .colon(colon),
    .bcd_out(bcd_out), .an_n(an_n), .dp_n(dp_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Advance the model across the upcoming clock edge using the inputs the DUT will sample
  task automatic model_edge();
    if (!en) m_act = 1'b0;
    else if (!m_act) begin
      m_act = 1'b1;
      m_t   = 0;
      mq[0] = d0; mq[1] = d1; mq[2] = d2; mq[3] = d3;
    end else begin
      m_t = (m_t + 1) % FRAME;
      if (m_t == 0) begin
        mq[0] = d0; mq[1] = d1; mq[2] = d2; mq[3] = d3;
      end
    end
  endtask

  // One clock: update model, then compare every output just after the edge
  task automatic cycle();
    int slot, off;
    logic [3:0] e_an, e_bcd;
    logic e_dp, e_fs;
    model_edge();
    e_an = 4'hF; e_bcd = 4'hF; e_dp = 1'b1; e_fs = 1'b0;
    if (m_act) begin
      slot  = m_t / RD;
      off   = m_t % RD;
      e_bcd = mq[slot];
      if (slot == 3 && lz_blank && mq[3] == 4'd0) e_bcd = 4'hF;
      if (off >= GD) begin
        e_an = 4'hF;
        e_an[slot] = 1'b0;
        e_dp = !(slot == 2 && colon);
      end
      e_fs = (m_t == 0);
    end
    @(posedge clk);
    #1;
    chk("an_n", an_n, e_an);
    chk("bcd_out", bcd_out, e_bcd);
    chk("dp_n", {3'b0, dp_n}, {3'b0, e_dp});
    chk("frame_start", {3'b0, frame_start}, {3'b0, e_fs});
    chk("one_anode", ($countones(~an_n) <= 1) ? 4'd1 : 4'd0, 4'd1);
  endtask

  // Run until the first lit cycle of the given slot, bounded
  task automatic run_to(input int slot);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME && !ok; i++) begin
      cycle();
      if (m_act && (m_t / RD) == slot && (m_t % RD) >= GD) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL run_to: slot %0d not reached, got timeout expected lit slot", slot);
    end
  endtask

  // Run until the last cycle of a frame, bounded
  task automatic run_to_end();
    for (int i = 0; i < 2 * FRAME && !(m_act && m_t == FRAME - 1); i++) cycle();
  endtask

  initial begin
    int dpc;
    tbl[0] = '{GD, 4'b1111, 4'd4}; tbl[1] = '{RD - GD, 4'b1110, 4'd4};
    tbl[2] = '{GD, 4'b1111, 4'd3}; tbl[3] = '{RD - GD, 4'b1101, 4'd3};
    tbl[4] = '{GD, 4'b1111, 4'd2}; tbl[5] = '{RD - GD, 4'b1011, 4'd2};
    tbl[6] = '{GD, 4'b1111, 4'd1}; tbl[7] = '{RD - GD, 4'b0111, 4'd1};

    reset = 1'b1; en = 1'b0; lz_blank = 1'b0; colon = 1'b0;
    d0 = 4'd4; d1 = 4'd3; d2 = 4'd2; d3 = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", an_n, 4'hF);
    chk("rst_bcd", bcd_out, 4'hF);
    chk("rst_dp", {3'b0, dp_n}, 4'd1);
    chk("rst_fs", {3'b0, frame_start}, 4'd0);
    en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Two frames from the explicit slot table
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 8; s++)
        for (int c = 0; c < tbl[s].n; c++) begin
          cycle();
          chk("tbl_an", an_n, tbl[s].an);
          chk("tbl_bcd", bcd_out, tbl[s].bcd);
          chk("tbl_fs", {3'b0, frame_start}, (s == 0 && c == 0) ? 4'd1 : 4'd0);
        end

    // Tear-free latch: change d0 during slot 2, new value only after next frame start
    run_to(2);
    d0 = 4'd9;
    run_to_end();
    cycle();
    chk("tear_fs", {3'b0, frame_start}, 4'd1);
    chk("tear_new", bcd_out, 4'd9);

    // Leading-zero blanking and pass-through of non-BCD codes
    d3 = 4'd0; lz_blank = 1'b1;
    run_to_end();
    run_to(3);
    chk("lz_bcd", bcd_out, 4'hF);
    chk("lz_an", an_n, 4'b0111);
    lz_blank = 1'b0;
    cycle();
    chk("lz_off_bcd", bcd_out, 4'd0);
    d1 = 4'hC;
    run_to_end();
    run_to(1);
    chk("pass_c", bcd_out, 4'hC);

    // Colon: decimal point lit only in slot 2 drive cycles
    colon = 1'b1;
    run_to_end();
    dpc = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (dp_n == 1'b0) dpc++;
    end
    chk("colon_on_cnt", 4'(dpc), 4'(RD - GD));
    colon = 1'b0;
    run_to_end();
    dpc = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (dp_n == 1'b0) dpc++;
    end
    chk("colon_off_cnt", 4'(dpc), 4'd0);

    // Disable mid-slot, then restart at digit 0
    run_to(1);
    en = 1'b0;
    cycle();
    chk("dis_an", an_n, 4'hF);
    chk("dis_bcd", bcd_out, 4'hF);
    chk("dis_dp", {3'b0, dp_n}, 4'd1);
    en = 1'b1;
    cycle();
    chk("reen_fs", {3'b0, frame_start}, 4'd1);
    chk("reen_bcd", bcd_out, d0);

    // Asynchronous reset between edges while driving
    colon = 1'b1;
    run_to(2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("areset_an", an_n, 4'hF);
    chk("areset_bcd", bcd_out, 4'hF);
    chk("areset_dp", {3'b0, dp_n}, 4'd1);
    chk("areset_fs", {3'b0, frame_start}, 4'd0);
    m_act = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en = ~en;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        d0 = 4'($urandom_range(0, 15)); d1 = 4'($urandom_range(0, 15));
        d2 = 4'($urandom_range(0, 15));
        d3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 7) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 7) == 0) colon = ~colon;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
